display_device: RTL and testbench

- Output-side counterpart of the button front end: consumes the edit-mode flag, field select and 8-bit value that the input side produces.
- Renders the value as up to three decimal digits on the board's multiplexed, active-low 3-digit seven-segment display.
- Converts binary to BCD with a sequential double-dabble engine, scans the digits, marks the selected field with a decimal point, and blinks the whole display while edit mode is active.

---
 rtl/display_device.sv | 231 +++++++++++++++++++++++
 tb/tb_display_device.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_device.sv
// display_device: sequential binary-to-BCD conversion of an 8-bit value, shown on a
// multiplexed active-low 3-digit seven-segment display with field DP and edit-mode blink.
module display_device #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ena,
    input  logic       i_wr,
    input  logic [1:0] i_sel,
    input  logic [7:0] i_val,
    output logic [7:0] o_seg,
    output logic [2:0] o_digit_en,
    output logic       o_busy
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [7:0]      val_r;
    logic [11:0]     bcd_r;
    logic            valid_r;
    logic            busy_r;
    logic [11:0]     scr_bcd_r;
    logic [7:0]      scr_bin_r;
    logic [2:0]      bit_cnt_r;
    logic [11:0]     adj_bcd_s;
    logic [RW-1:0]   refresh_cnt_r, refresh_cnt_nxt_s;
    logic [1:0]      idx_r, idx_nxt_s;
    logic [BW-1:0]   blink_cnt_r, blink_cnt_nxt_s;
    logic            blink_on_r, blink_on_nxt_s;
    logic [11:0]     disp_bcd_s;
    logic            disp_valid_s;
    logic [3:0]      digit_s;
    logic            lit_s;
    logic [7:0]      seg_nxt_s, seg_r;
    logic [2:0]      en_nxt_s, en_r;

    function automatic logic [11:0] dabble_adjust(input logic [11:0] bcd);
        logic [11:0] r;
        r = bcd;
        for (int i = 0; i < 3; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            else                     r[4*i +: 4] = r[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Conversion FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_r <= IDLE;
        else          state_r <= state_nxt_s;
    end

    // Conversion FSM next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!valid_r || (i_val != val_r)) state_nxt_s = LOAD;
                else                              state_nxt_s = IDLE;
            end
            LOAD:  state_nxt_s = SHIFT;
            SHIFT: begin
                if (bit_cnt_r == 3'd7) state_nxt_s = DONE;
                else                   state_nxt_s = SHIFT;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    assign adj_bcd_s = dabble_adjust(scr_bcd_r);

    // Double-dabble datapath: capture, shift with nibble correction, publish result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            val_r     <= 8'd0;
            bcd_r     <= 12'd0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            scr_bcd_r <= 12'd0;
            scr_bin_r <= 8'd0;
            bit_cnt_r <= 3'd0;
        end else begin
            case (state_r)
                LOAD: begin
                    val_r     <= i_val;
                    scr_bcd_r <= 12'd0;
                    scr_bin_r <= i_val;
                    bit_cnt_r <= 3'd0;
                    busy_r    <= 1'b1;
                end
                SHIFT: begin
                    {scr_bcd_r, scr_bin_r} <= {adj_bcd_s[10:0], scr_bin_r, 1'b0};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
                DONE: begin
                    bcd_r   <= scr_bcd_r;
                    valid_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: busy_r <= 1'b0;
            endcase
        end
    end

    // Digit scan: refresh divider and slot index
    always_comb begin
        refresh_cnt_nxt_s = refresh_cnt_r;
        idx_nxt_s         = idx_r;
        if (i_ena) begin
            if (refresh_cnt_r == REFRESH_MAX) begin
                refresh_cnt_nxt_s = {RW{1'b0}};
                idx_nxt_s         = (idx_r == 2'd2) ? 2'd0 : idx_r + 2'd1;
            end else begin
                refresh_cnt_nxt_s = refresh_cnt_r + RW'(1);
                idx_nxt_s         = idx_r;
            end
        end else begin
            refresh_cnt_nxt_s = refresh_cnt_r;
            idx_nxt_s         = idx_r;
        end
    end

    // Blink divider; leaving edit mode forces the on phase immediately
    always_comb begin
        blink_cnt_nxt_s = blink_cnt_r;
        blink_on_nxt_s  = blink_on_r;
        if (!i_wr) begin
            blink_cnt_nxt_s = {BW{1'b0}};
            blink_on_nxt_s  = 1'b1;
        end else if (i_ena) begin
            if (blink_cnt_r == BLINK_MAX) begin
                blink_cnt_nxt_s = {BW{1'b0}};
                blink_on_nxt_s  = ~blink_on_r;
            end else begin
                blink_cnt_nxt_s = blink_cnt_r + BW'(1);
                blink_on_nxt_s  = blink_on_r;
            end
        end else begin
            blink_cnt_nxt_s = blink_cnt_r;
            blink_on_nxt_s  = blink_on_r;
        end
    end

    // Output frame is built from post-edge state so segments and enables move together
    always_comb begin
        disp_valid_s = valid_r | (state_r == DONE);
        disp_bcd_s   = (state_r == DONE) ? scr_bcd_r : bcd_r;
        digit_s      = 4'd0;
        lit_s        = 1'b0;
        seg_nxt_s    = 8'hFF;
        en_nxt_s     = 3'b111;
        case (idx_nxt_s)
            2'd0: begin
                digit_s = disp_bcd_s[3:0];
                lit_s   = 1'b1;
            end
            2'd1: begin
                digit_s = disp_bcd_s[7:4];
                lit_s   = |disp_bcd_s[11:4];
            end
            2'd2: begin
                digit_s = disp_bcd_s[11:8];
                lit_s   = |disp_bcd_s[11:8];
            end
            default: begin
                digit_s = 4'd0;
                lit_s   = 1'b0;
            end
        endcase
        if (disp_valid_s && lit_s && blink_on_nxt_s) begin
            seg_nxt_s = {(idx_nxt_s != i_sel), glyph(digit_s)};
            en_nxt_s  = ~(3'b001 << idx_nxt_s);
        end else begin
            seg_nxt_s = 8'hFF;
            en_nxt_s  = 3'b111;
        end
    end

    // Scan, blink and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            refresh_cnt_r <= {RW{1'b0}};
            idx_r         <= 2'd0;
            blink_cnt_r   <= {BW{1'b0}};
            blink_on_r    <= 1'b1;
            seg_r         <= 8'hFF;
            en_r          <= 3'b111;
        end else begin
            refresh_cnt_r <= refresh_cnt_nxt_s;
            idx_r         <= idx_nxt_s;
            blink_cnt_r   <= blink_cnt_nxt_s;
            blink_on_r    <= blink_on_nxt_s;
            seg_r         <= seg_nxt_s;
            en_r          <= en_nxt_s;
        end
    end

    assign o_seg      = seg_r;
    assign o_digit_en = en_r;
    assign o_busy     = busy_r;

endmodule

// File: tb/tb_display_device.sv
// Self-checking bench for display_device: random and directed stimulus compared every
// cycle against an arithmetic model of conversion timing, scan slot and blink phase.
module tb_display_device;
    localparam int REFRESH_DIV = 4;
    localparam int BLINK_DIV   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic       wr = 1'b0;
    logic [1:0] sel = 2'd3;
    logic [7:0] val = 8'd0;
    logic [7:0] seg;
    logic [2:0] digit_en;
    logic       busy;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    int   edge_n = 0;
    int   conv_start, idle_from, ena_cnt, wr_cnt, m_cap, m_disp;
    bit   conv_active, m_valid;
    logic [7:0] exp_seg;
    logic [2:0] exp_en;
    logic       exp_busy;
    logic [6:0] glyph_tbl [10];

    always #5 clk = ~clk;

    display_device #(.REFRESH_DIV(REFRESH_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_wr(wr), .i_sel(sel), .i_val(val),
        .o_seg(seg), .o_digit_en(digit_en), .o_busy(busy)
    );

    task automatic model_reset();
        conv_active = 1'b0; m_valid = 1'b0; m_cap = 0; m_disp = 0;
        ena_cnt = 0; wr_cnt = 0; conv_start = 0; idle_from = edge_n + 1;
        exp_seg = 8'hFF; exp_en = 3'b111; exp_busy = 1'b0;
    endtask

    task automatic model_outputs();
        int  d [3];
        int  idx;
        bit  lit, on;
        d[0] = m_disp % 10; d[1] = (m_disp / 10) % 10; d[2] = m_disp / 100;
        idx  = (ena_cnt / REFRESH_DIV) % 3;
        on   = ((wr_cnt / BLINK_DIV) % 2) == 0;
        lit  = (idx == 0) || (idx == 1 && m_disp >= 10) || (idx == 2 && m_disp >= 100);
        exp_busy = conv_active && (edge_n >= conv_start + 1);
        if (m_valid && on && lit) begin
            exp_seg = {(idx != int'(sel)), glyph_tbl[d[idx]]};
            exp_en  = ~(3'b001 << idx);
        end else begin
            exp_seg = 8'hFF;
            exp_en  = 3'b111;
        end
    endtask

    // one clock edge: advance the model with the inputs the DUT sampled, then settle
    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (ena) ena_cnt++;
            if (!wr) wr_cnt = 0;
            else if (ena) wr_cnt++;
            if (conv_active) begin
                if (edge_n == conv_start + 1) m_cap = int'(val);
                if (edge_n == conv_start + 10) begin
                    m_disp = m_cap; m_valid = 1'b1; conv_active = 1'b0; idle_from = edge_n + 1;
                end
            end else if (edge_n >= idle_from && (!m_valid || int'(val) != m_cap)) begin
                conv_active = 1'b1; conv_start = edge_n;
            end
            model_outputs();
        end
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        n_cmp++;
        if ({seg, digit_en, busy} !== {8'hFF, 3'b111, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async got seg=%h en=%b busy=%b want seg=ff en=111 busy=0", seg, digit_en, busy);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({seg, digit_en, busy} !== {exp_seg, exp_en, exp_busy}) begin
                n_fail++;
                $display("FAIL reset_hold got %h/%b/%b want %h/%b/%b", seg, digit_en, busy, exp_seg, exp_en, exp_busy);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        int busy_cycles = 0;
        val = 8'd0; sel = 2'd3;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (busy === 1'b1) busy_cycles++;
            n_cmp++;
            if ({seg, digit_en, busy} !== {exp_seg, exp_en, exp_busy}) begin
                n_fail++;
                $display("FAIL zero_conv t=%0t got %h/%b/%b want %h/%b/%b", $time, seg, digit_en, busy, exp_seg, exp_en, exp_busy);
            end
        end
        n_cmp++;
        if (busy_cycles != 9) begin
            n_fail++;
            $display("FAIL zero_busy_len got %0d want 9", busy_cycles);
        end
    endtask

    task automatic test_values();
        logic [7:0] vals [3] = '{8'd255, 8'd7, 8'd7};
        logic [1:0] sels [3] = '{2'd3, 2'd0, 2'd1};
        for (int k = 0; k < 9; k++) begin
            if (k < 3) begin
                val = vals[k]; sel = sels[k];
            end else begin
                val = 8'($urandom_range(0, 255)); sel = 2'($urandom_range(0, 3));
            end
            for (int i = 0; i < 24; i++) begin
                tick();
                n_cmp++;
                if ({seg, digit_en, busy} !== {exp_seg, exp_en, exp_busy}) begin
                    n_fail++;
                    $display("FAIL value_%0d t=%0t val=%0d sel=%0d got %h/%b/%b want %h/%b/%b", val, $time, val, sel, seg, digit_en, busy, exp_seg, exp_en, exp_busy);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        val = 8'd100; sel = 2'd2;
        for (int i = 0; i < 24; i++) tick();
        val = 8'd42;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 2) val = 8'd9;
            n_cmp++;
            if ({seg, digit_en, busy} !== {exp_seg, exp_en, exp_busy}) begin
                n_fail++;
                $display("FAIL back_to_back step=%0d got %h/%b/%b want %h/%b/%b", i, seg, digit_en, busy, exp_seg, exp_en, exp_busy);
            end
        end
    endtask

    task automatic test_blink();
        int off_cycles = 0;
        val = 8'd123; sel = 2'd3; wr = 1'b0;
        for (int i = 0; i < 24; i++) tick();
        wr = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (i < 64 && digit_en === 3'b111) off_cycles++;
            n_cmp++;
            if ({seg, digit_en, busy} !== {exp_seg, exp_en, exp_busy}) begin
                n_fail++;
                $display("FAIL blink step=%0d got %h/%b/%b want %h/%b/%b", i, seg, digit_en, busy, exp_seg, exp_en, exp_busy);
            end
        end
        n_cmp++;
        if (off_cycles != 32) begin
            n_fail++;
            $display("FAIL blink_off_len got %0d want 32", off_cycles);
        end
        wr = 1'b0;
        tick();
        n_cmp++;
        if (digit_en === 3'b111 || {seg, digit_en} !== {exp_seg, exp_en}) begin
            n_fail++;
            $display("FAIL blink_exit got %h/%b want %h/%b", seg, digit_en, exp_seg, exp_en);
        end
    endtask

    task automatic test_ena_hold();
        for (int i = 0; i < 80; i++) begin
            ena = 1'($urandom_range(0, 1));
            if (i % 20 == 0) val = 8'($urandom_range(0, 255));
            wr = (i >= 40);
            tick();
            n_cmp++;
            if ({seg, digit_en, busy} !== {exp_seg, exp_en, exp_busy}) begin
                n_fail++;
                $display("FAIL ena_hold step=%0d got %h/%b/%b want %h/%b/%b", i, seg, digit_en, busy, exp_seg, exp_en, exp_busy);
            end
        end
        ena = 1'b1; wr = 1'b0;
    endtask

    task automatic test_reset_mid();
        val = 8'd200; sel = 2'd1;
        for (int i = 0; i < 5; i++) tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({seg, digit_en, busy} !== {8'hFF, 3'b111, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid got %h/%b/%b want ff/111/0", seg, digit_en, busy);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++;
            if ({seg, digit_en, busy} !== {exp_seg, exp_en, exp_busy}) begin
                n_fail++;
                $display("FAIL reset_restart step=%0d got %h/%b/%b want %h/%b/%b", i, seg, digit_en, busy, exp_seg, exp_en, exp_busy);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) val = 8'($urandom_range(0, 255));
            if (i % 7 == 0) sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) wr = ~wr;
            tick();
            n_cmp++;
            if ({seg, digit_en, busy} !== {exp_seg, exp_en, exp_busy}) begin
                n_fail++;
                $display("FAIL random step=%0d val=%0d got %h/%b/%b want %h/%b/%b", i, val, seg, digit_en, busy, exp_seg, exp_en, exp_busy);
            end
        end
        wr = 1'b0;
    endtask

    initial begin
        glyph_tbl[0] = 7'b1000000; glyph_tbl[1] = 7'b1111001;
        glyph_tbl[2] = 7'b0100100; glyph_tbl[3] = 7'b0110000;
        glyph_tbl[4] = 7'b0011001; glyph_tbl[5] = 7'b0010010;
        glyph_tbl[6] = 7'b0000010; glyph_tbl[7] = 7'b1111000;
        glyph_tbl[8] = 7'b0000000; glyph_tbl[9] = 7'b0010000;
        model_reset();
        test_reset();
        test_zero();
        test_values();
        test_back_to_back();
        test_blink();
        test_ena_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
